// File: rtl/i2c_master_wr.sv
// rtl/i2c_master_wr.sv - I2C write master: START, {addr,W}, two data bytes, STOP
// One phase tick per CLK_DIV clocks; every SCLK/SDAT update is registered on a tick.
module i2c_master_wr #(
   parameter int CLK_DIV = 125
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [6:0]  addr,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        nack,
   output logic        I2C_SCLK,
   inout  wire         I2C_SDAT
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACK,
      S_STOP,
      S_DONE
   } state_t;

   localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

   state_t      state_q;
   logic [1:0]  phase_q;
   logic [1:0]  byte_q;
   logic [2:0]  bit_q;
   logic [23:0] shift_q;
   logic [11:0] div_q;
   logic [11:0] div_d;
   logic        busy_q;
   logic        done_q;
   logic        nack_q;
   logic        scl_q;
   logic        sda_low_q;
   logic        accept;
   logic        tick;

   assign accept = start && !busy_q;
   assign tick   = busy_q && (div_q == DIV_LAST);

   // The acceptance cycle itself counts as divider position 0, so cycle 1 holds 1.
   always_comb begin
      div_d = 12'd0;
      if (accept) begin
         div_d = 12'd1;
      end else if (busy_q) begin
         div_d = tick ? 12'd0 : div_q + 12'd1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= S_IDLE;
         phase_q   <= 2'd0;
         byte_q    <= 2'd0;
         bit_q     <= 3'd0;
         shift_q   <= 24'd0;
         div_q     <= 12'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         nack_q    <= 1'b0;
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
      end else begin
         div_q <= div_d;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               if (start) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
                  nack_q  <= 1'b0;
                  shift_q <= {addr, 1'b0, wdata};
                  phase_q <= 2'd0;
                  bit_q   <= 3'd7;
                  byte_q  <= 2'd0;
               end
            end
            S_START: if (tick) begin
               if (phase_q == 2'd0) begin
                  sda_low_q <= 1'b1;
                  phase_q   <= 2'd1;
               end else begin
                  scl_q   <= 1'b0;
                  phase_q <= 2'd0;
                  state_q <= S_BIT;
               end
            end
            S_BIT: if (tick) begin
               phase_q <= phase_q + 2'd1;
               if (phase_q == 2'd0) sda_low_q <= !shift_q[23];
               if (phase_q == 2'd1) scl_q <= 1'b1;
               if (phase_q == 2'd3) begin
                  scl_q   <= 1'b0;
                  shift_q <= {shift_q[22:0], 1'b0};
                  bit_q   <= bit_q - 3'd1;
                  if (bit_q == 3'd0) state_q <= S_ACK;
               end
            end
            S_ACK: if (tick) begin
               phase_q <= phase_q + 2'd1;
               if (phase_q == 2'd0) sda_low_q <= 1'b0;
               if (phase_q == 2'd1) scl_q <= 1'b1;
               // Slave response is sampled as the high half of the ACK clock ends.
               if (phase_q == 2'd3) begin
                  scl_q <= 1'b0;
                  if (I2C_SDAT) begin
                     nack_q  <= 1'b1;
                     state_q <= S_STOP;
                  end else if (byte_q == 2'd2) begin
                     state_q <= S_STOP;
                  end else begin
                     byte_q  <= byte_q + 2'd1;
                     state_q <= S_BIT;
                  end
               end
            end
            S_STOP: if (tick) begin
               phase_q <= phase_q + 2'd1;
               if (phase_q == 2'd0) begin
                  scl_q     <= 1'b0;
                  sda_low_q <= 1'b1;
               end
               if (phase_q == 2'd1) scl_q <= 1'b1;
               if (phase_q == 2'd2) begin
                  sda_low_q <= 1'b0;
                  phase_q   <= 2'd0;
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign nack     = nack_q;
   assign I2C_SCLK = scl_q;
   assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb/tb_i2c_master_wr.sv - bench for i2c_master_wr with a behavioural I2C slave
// Expected bytes, completion cycle and nack come from the frame rules, not the RTL.
module tb_i2c_master_wr;

   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  addr = 7'd0;
   logic [15:0] wdata = 16'd0;
   logic        busy;
   logic        done;
   logic        nack;
   logic        scl;
   wire         sda;

   logic        slv_drive = 1'b0;
   int          ack_limit = 3;

   int checks = 0;
   int errors = 0;

   assign sda = slv_drive ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_master_wr #(.CLK_DIV(CD)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .start    (start),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .nack     (nack),
      .I2C_SCLK (scl),
      .I2C_SDAT (sda)
   );

   always #5 clk = ~clk;

   // Slave: ACKs the first ack_limit bytes of a frame; also counts SDA edges under SCL high.
   logic       scl_prev = 1'b1;
   logic       sda_prev = 1'b1;
   logic       slv_active = 1'b0;
   logic       slv_in_ack = 1'b0;
   int         slv_bits = 0;
   int         slv_byte = 0;
   logic [7:0] slv_sh = 8'd0;
   logic [7:0] rx_q[$];
   int         stop_cnt = 0;
   int         mon_edges = 0;

   always @(scl or sda or nreset) begin
      if (!nreset) begin
         slv_active = 1'b0;
         slv_in_ack = 1'b0;
         slv_drive  = 1'b0;
         slv_bits   = 0;
      end else begin
         if (scl_prev === 1'b1 && scl === 1'b1 && sda !== sda_prev) begin
            mon_edges++;
            if (sda === 1'b0) begin
               slv_active = 1'b1;
               slv_in_ack = 1'b0;
               slv_bits   = 0;
               slv_byte   = 0;
            end else begin
               if (slv_active) stop_cnt++;
               slv_active = 1'b0;
            end
         end else if (slv_active && scl_prev === 1'b0 && scl === 1'b1 && !slv_in_ack) begin
            slv_sh = {slv_sh[6:0], (sda === 1'b1)};
            slv_bits++;
            if (slv_bits == 8) rx_q.push_back(slv_sh);
         end else if (slv_active && scl_prev === 1'b1 && scl === 1'b0) begin
            if (slv_in_ack) begin
               slv_in_ack = 1'b0;
               slv_drive  = 1'b0;
               slv_bits   = 0;
               slv_byte++;
            end else if (slv_bits == 8) begin
               slv_in_ack = 1'b1;
               slv_drive  = (slv_byte < ack_limit);
            end
         end
      end
      scl_prev = scl;
      sda_prev = sda;
   end

   task automatic launch_now(input logic [6:0] a, input logic [15:0] d);
      addr  = a;
      wdata = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic launch(input logic [6:0] a, input logic [15:0] d);
      @(negedge clk);
      launch_now(a, d);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 5;
      if (scl !== 1'b1)  begin errors++; $display("FAIL reset_scl got %b want 1", scl); end
      if (sda !== 1'b1)  begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (nack !== 1'b0) begin errors++; $display("FAIL reset_nack got %b want 0", nack); end
      @(negedge clk);
      nreset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks += 2;
      if (scl !== 1'b1 || sda !== 1'b1) begin
         errors++; $display("FAIL idle_lines got scl=%b sda=%b want 1 1", scl, sda);
      end
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_full_frame();
      int cyc, rx0, e0;
      ack_limit = 3;
      rx0 = rx_q.size();
      e0  = mon_edges;
      launch(7'h1A, 16'h1E00);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_c1 got %b want 1", busy); end
      wait_done(cyc);
      checks += 4;
      if (cyc != 113 * CD) begin errors++; $display("FAIL full_done_cycle got %0d want %0d", cyc, 113 * CD); end
      if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_done got %b want 0", busy); end
      if (nack !== 1'b0) begin errors++; $display("FAIL full_nack got %b want 0", nack); end
      if (rx_q.size() - rx0 != 3) begin
         errors++; $display("FAIL full_rx_count got %0d want 3", rx_q.size() - rx0);
      end else begin
         checks += 3;
         if (rx_q[rx0] !== 8'h34)     begin errors++; $display("FAIL full_addr got %h want 34", rx_q[rx0]); end
         if (rx_q[rx0 + 1] !== 8'h1E) begin errors++; $display("FAIL full_b1 got %h want 1e", rx_q[rx0 + 1]); end
         if (rx_q[rx0 + 2] !== 8'h00) begin errors++; $display("FAIL full_b2 got %h want 00", rx_q[rx0 + 2]); end
      end
      @(posedge clk);
      #1;
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %b want 0", done); end
      if (mon_edges - e0 != 2) begin errors++; $display("FAIL full_sda_edges got %0d want 2", mon_edges - e0); end
   endtask

   task automatic test_no_slave();
      int cyc, rx0, e0, s0;
      ack_limit = 0;
      rx0 = rx_q.size();
      e0  = mon_edges;
      s0  = stop_cnt;
      launch(7'h1A, 16'h1E00);
      wait_done(cyc);
      checks += 5;
      if (cyc != 41 * CD) begin errors++; $display("FAIL nack_done_cycle got %0d want %0d", cyc, 41 * CD); end
      if (nack !== 1'b1) begin errors++; $display("FAIL nack_flag got %b want 1", nack); end
      if (stop_cnt - s0 != 1) begin errors++; $display("FAIL nack_stop got %0d want 1", stop_cnt - s0); end
      if (rx_q.size() - rx0 != 1 || rx_q[rx_q.size() - 1] !== 8'h34) begin
         errors++; $display("FAIL nack_rx got %0d bytes want 1 byte 34", rx_q.size() - rx0);
      end
      if (mon_edges - e0 != 2) begin errors++; $display("FAIL nack_sda_edges got %0d want 2", mon_edges - e0); end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (nack !== 1'b1) begin errors++; $display("FAIL nack_sticky got %b want 1", nack); end
   endtask

   task automatic test_random();
      int cyc, rx0, e0, nbytes;
      logic [6:0]  a;
      logic [15:0] d;
      logic [7:0]  exp_b[3];
      for (int it = 0; it < 6; it++) begin
         a = 7'($urandom);
         d = 16'($urandom);
         ack_limit = int'($urandom_range(0, 3));
         nbytes = (ack_limit >= 3) ? 3 : ack_limit + 1;
         exp_b[0] = {a, 1'b0};
         exp_b[1] = d[15:8];
         exp_b[2] = d[7:0];
         rx0 = rx_q.size();
         e0  = mon_edges;
         launch(a, d);
         wait_done(cyc);
         checks += 4;
         if (cyc != (5 + 36 * nbytes) * CD) begin
            errors++; $display("FAIL rand%0d_done_cycle got %0d want %0d", it, cyc, (5 + 36 * nbytes) * CD);
         end
         if (nack !== (ack_limit < 3)) begin
            errors++; $display("FAIL rand%0d_nack got %b want %b", it, nack, ack_limit < 3);
         end
         if (mon_edges - e0 != 2) begin
            errors++; $display("FAIL rand%0d_sda_edges got %0d want 2", it, mon_edges - e0);
         end
         if (rx_q.size() - rx0 != nbytes) begin
            errors++; $display("FAIL rand%0d_rx_count got %0d want %0d", it, rx_q.size() - rx0, nbytes);
         end else begin
            for (int k = 0; k < nbytes; k++) begin
               checks++;
               if (rx_q[rx0 + k] !== exp_b[k]) begin
                  errors++; $display("FAIL rand%0d_byte%0d got %h want %h", it, k, rx_q[rx0 + k], exp_b[k]);
               end
            end
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, rx0;
      ack_limit = 0;
      rx0 = rx_q.size();
      launch(7'h1A, 16'h1234);
      cyc = 1;
      while (cyc < 100) begin @(posedge clk); #1; cyc++; end
      addr  = 7'h55;
      wdata = 16'hBEEF;
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      while (done !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
      checks += 4;
      if (cyc != 41 * CD) begin errors++; $display("FAIL b2b_ignored_cycle got %0d want %0d", cyc, 41 * CD); end
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done got %b want 0", busy); end
      if (nack !== 1'b1) begin errors++; $display("FAIL b2b_nack got %b want 1", nack); end
      if (rx_q.size() - rx0 != 1 || rx_q[rx_q.size() - 1] !== 8'h34) begin
         errors++; $display("FAIL b2b_latched_addr got %0d bytes last %h want 1 byte 34",
                            rx_q.size() - rx0, rx_q[rx_q.size() - 1]);
      end
      ack_limit = 3;
      rx0 = rx_q.size();
      launch_now(7'h2B, 16'hA5C3);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got %b want 1", busy); end
      if (nack !== 1'b0) begin errors++; $display("FAIL b2b_nack_clear got %b want 0", nack); end
      wait_done(cyc);
      checks += 2;
      if (cyc != 113 * CD) begin errors++; $display("FAIL b2b_done_cycle got %0d want %0d", cyc, 113 * CD); end
      if (rx_q.size() - rx0 != 3 || rx_q[rx0] !== 8'h56 || rx_q[rx0 + 1] !== 8'hA5 || rx_q[rx0 + 2] !== 8'hC3) begin
         errors++; $display("FAIL b2b_bytes got %0d bytes want 56 a5 c3", rx_q.size() - rx0);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, rx0, e0;
      ack_limit = 3;
      launch(7'h1A, 16'h0500);
      cyc = 1;
      while (cyc < 56 * CD + 1) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (scl !== 1'b1 || sda !== 1'b0) begin
         errors++; $display("FAIL mid_bit3_lines got scl=%b sda=%b want 1 0", scl, sda);
      end
      nreset = 1'b0;
      #1;
      checks += 3;
      if (scl !== 1'b1)  begin errors++; $display("FAIL mid_reset_scl got %b want 1", scl); end
      if (sda !== 1'b1)  begin errors++; $display("FAIL mid_reset_sda got %b want 1", sda); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || nack !== 1'b0 || scl !== 1'b1) begin
         errors++; $display("FAIL mid_after_release got done=%b nack=%b scl=%b want 0 0 1", done, nack, scl);
      end
      rx0 = rx_q.size();
      e0  = mon_edges;
      launch(7'h1A, 16'h1E00);
      wait_done(cyc);
      checks += 4;
      if (cyc != 113 * CD) begin errors++; $display("FAIL mid_restart_cycle got %0d want %0d", cyc, 113 * CD); end
      if (nack !== 1'b0) begin errors++; $display("FAIL mid_restart_nack got %b want 0", nack); end
      if (mon_edges - e0 != 2) begin errors++; $display("FAIL mid_sda_edges got %0d want 2", mon_edges - e0); end
      if (rx_q.size() - rx0 != 3 || rx_q[rx0] !== 8'h34 || rx_q[rx0 + 1] !== 8'h1E || rx_q[rx0 + 2] !== 8'h00) begin
         errors++; $display("FAIL mid_restart_bytes got %0d bytes want 34 1e 00", rx_q.size() - rx0);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_no_slave();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 Parameter CLK_DIV, default 125, clk cycles per I2C quarter-bit phase; legal range 2..4095.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nreset  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  transaction request; sampled only when busy is low.
REQ-005 addr  input  7  7-bit slave address; latched on acceptance.
REQ-006 wdata  input  16  write payload; latched on acceptance; high byte sent first.
REQ-007 busy  output  1  high from the cycle after acceptance until the done cycle.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 nack  output  1  sticky error flag; cleared on the next acceptance.
REQ-010 I2C_SCLK  output  1  I2C clock, push-pull, idle high.
REQ-011 I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or high-Z only, never 1; external pullup.

Function
REQ-012 Acceptance: start=1 and busy=0 in cycle 0; addr and wdata latched; nack cleared; phase divider zeroed; busy=1 from cycle 1.
REQ-013 A phase tick occurs every CLK_DIV cycles after acceptance; every SCLK/SDAT change happens only on a tick.
REQ-014 Frame: START, byte {addr,0} (write), ACK, wdata[15:8], ACK, wdata[7:0], ACK, STOP; all bytes MSB first.
REQ-015 FSM states: IDLE, START, BIT, ACK, STOP, DONE; 3-bit bit counter (7 down to 0); 2-bit byte counter (0..2).
REQ-016 START, 2 phases: SDAT released to pulled low with SCLK high; then SCLK low.
REQ-017 BIT, 4 phases: p0 SCLK low, SDAT set to data bit; p1 SCLK high; p2 SCLK high; p3 SCLK low.
REQ-018 ACK, 4 phases like BIT with SDAT released in p0; SDAT sampled at the end of p2; 0=ACK, 1=NACK.
REQ-019 ACK after bit 0 of a byte; next byte after ACK if byte counter < 2; STOP after the third ACK.
REQ-020 NACK in any ACK slot: nack set, remaining bytes skipped, go directly to STOP.
REQ-021 STOP, 3 phases: SCLK low, SDAT low; SCLK high, SDAT low; SDAT released with SCLK high.
REQ-022 DONE: done=1 and busy=0 in the same cycle, one cycle after the final STOP tick; return to IDLE.
REQ-023 Full transaction length: 2+27*4+3 = 113 ticks; done in cycle 113*CLK_DIV.
REQ-024 NACK on the address: 2+9*4+3 = 41 ticks; done in cycle 41*CLK_DIV.
REQ-025 start while busy=1: ignored, no effect on latched data or the FSM.
REQ-026 start in the done cycle: accepted, because busy is already low.
REQ-027 SDAT changes while SCLK is high only at the START and STOP points.

Reset
REQ-028 nreset low: immediately forces IDLE, I2C_SCLK=1, I2C_SDAT=Z, busy=0, done=0, nack=0, counters 0.
REQ-029 Reset mid-transaction: abandons the frame with no STOP generated; the next start after release runs a full frame.

Verification
REQ-030 Reset with no start -> SCLK=1, SDAT reads 1 via pullup, busy=0, done=0, nack=0.
REQ-031 CLK_DIV=4, ACKing i2c slave model, addr=0x1A, wdata=0x1E00 -> slave reports address 0x34, bytes 0x1E then 0x00; done at cycle 452; nack=0.
REQ-032 CLK_DIV=4, pullup only (no slave), addr=0x1A -> NACK on address; STOP issued; done at cycle 164; nack=1 and held until the next acceptance.
REQ-033 start pulsed at cycle 100 of an active frame, then again in its done cycle -> first pulse ignored; second accepted; busy high from the next cycle; nack cleared.
REQ-034 nreset pulsed low during wdata[15:8] bit 3 -> SCLK=1 and SDAT=Z within the same cycle; busy=0; following start completes a full 113*CLK_DIV frame.
REQ-035 Protocol monitor over all scenarios -> no SDAT edge while SCLK is high except START and STOP; SDAT never driven to 1.
